// File: rtl/counter_sample_pkg.sv
// Shared types and helpers for the counter sample FIFO.
//   sample_t  : one buffered sample {value, delta, first}
//   mod_delta : modular difference of two counter readings
package counter_sample_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] value;
    logic [DATA_W_DEFAULT-1:0] delta;
    logic                      first;
  } sample_t;

  // Natural wrap: truncation to DATA_W gives the modular difference.
  function automatic logic [DATA_W_DEFAULT-1:0] mod_delta(
    input logic [DATA_W_DEFAULT-1:0] cur,
    input logic [DATA_W_DEFAULT-1:0] prev
  );
    return DATA_W_DEFAULT'(cur - prev);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO of sample_t entries.
// Ports: clk, rst (sync, active-high), push_i/push_data_i, pop_i,
//        head_o (zero while empty), full_o, empty_o, level_o.
// A push while full is accepted only together with a pop.
module sample_fifo
  import counter_sample_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  sample_t                      push_data_i,
  input  logic                         pop_i,
  output sample_t                      head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  sample_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]   level_q,  level_d;
  logic               do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap modulo DEPTH.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/counter_sample_fifo.sv
// Samples an upstream counter every (div+1) enabled cycles, forms the
// modular delta to the previous accepted sample and buffers {value,
// delta, first} in an FWFT FIFO drained by a valid/ready consumer.
// Ports: clk, rst (sync, active-high), en, div, cnt_in,
//        out_valid/out_ready/out_data/out_delta/out_first,
//        overflow (sticky) with ovf_clr, level.
// Optional macro COUNTER_SAMPLE_FIFO_DROP_CNT_EN adds drop_cnt[15:0],
// a saturating count of dropped samples, also cleared by ovf_clr.
module counter_sample_fifo
  import counter_sample_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DIV_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [DIV_W-1:0]            div,
  input  logic [DATA_W-1:0]           cnt_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [DATA_W-1:0]           out_delta,
  output logic                        out_first,
  output logic                        overflow,
  input  logic                        ovf_clr,
  output logic [$clog2(DEPTH+1)-1:0]  level
`ifdef COUNTER_SAMPLE_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]                 drop_cnt
`endif
);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              first_pending_q, first_pending_d;
  logic              overflow_q, overflow_d;
  logic              tick_c, pop_c, push_c, drop_c, full_c, empty_c;
  sample_t           sample_c, head_c;

  // Divider compares against the live div value, so a shrink below the
  // current count runs the counter round to its natural wrap.
  assign tick_c  = en && (div_cnt_q == div);
  assign pop_c   = !empty_c && out_ready;
  assign push_c  = tick_c && (!full_c || pop_c);
  assign drop_c  = tick_c && full_c && !pop_c;

  always_comb begin
    sample_c.value = DATA_W_DEFAULT'(cnt_in);
    sample_c.delta = first_pending_q ? '0
                   : mod_delta(DATA_W_DEFAULT'(cnt_in), DATA_W_DEFAULT'(prev_q));
    sample_c.first = first_pending_q;
  end

  // Dropped samples leave prev/first untouched so accepted deltas sum
  // to the net counter change.
  always_comb begin
    div_cnt_d       = div_cnt_q;
    prev_d          = prev_q;
    first_pending_d = first_pending_q;
    overflow_d      = overflow_q;
    if (!en) begin
      div_cnt_d       = '0;
      first_pending_d = 1'b1;
    end else if (tick_c) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
    if (push_c) begin
      prev_d          = cnt_in;
      first_pending_d = 1'b0;
    end
    if (drop_c)       overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q       <= '0;
      prev_q          <= '0;
      first_pending_q <= 1'b1;
      overflow_q      <= 1'b0;
    end else begin
      div_cnt_q       <= div_cnt_d;
      prev_q          <= prev_d;
      first_pending_q <= first_pending_d;
      overflow_q      <= overflow_d;
    end
  end

`ifdef COUNTER_SAMPLE_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; a drop in the clear cycle counts as one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr)                          drop_cnt_d = drop_c ? 16'd1 : 16'd0;
    else if (drop_c && drop_cnt_q != '1)  drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_c),
    .push_data_i (sample_c),
    .pop_i       (pop_c),
    .head_o      (head_c),
    .full_o      (full_c),
    .empty_o     (empty_c),
    .level_o     (level)
  );

  assign out_valid = !empty_c;
  assign out_data  = DATA_W'(head_c.value);
  assign out_delta = DATA_W'(head_c.delta);
  assign out_first = head_c.first;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_counter_sample_fifo.sv
// Self-checking bench for counter_sample_fifo (DATA_W=8, DEPTH=4, DIV_W=8).
module tb_counter_sample_fifo;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [7:0] value;
    logic [7:0] delta;
    logic       first;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, en, out_ready, ovf_clr;
  logic [7:0] div, cnt_in;
  logic       out_valid, out_first, overflow;
  logic [7:0] out_data, out_delta;
  logic [2:0] level;
`ifdef COUNTER_SAMPLE_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard and reference state
  exp_t       sb[$];
  logic [7:0] m_div;
  logic [7:0] m_prev;
  logic       m_first;
  logic       m_ovf;

  counter_sample_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div       (div),
    .cnt_in    (cnt_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_delta (out_delta),
    .out_first (out_first),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .level     (level)
`ifdef COUNTER_SAMPLE_FIFO_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus at a negedge, update the reference,
  // and return at the following negedge.
  task automatic drive(input logic r, input logic e, input logic [7:0] d,
                       input logic [7:0] c, input logic rdy, input logic clr);
    logic tk, pp, ps, dr, fl;
    exp_t s;
    rst = r; en = e; div = d; cnt_in = c; out_ready = rdy; ovf_clr = clr;
    if (r) begin
      sb.delete();
      m_div = 8'd0; m_prev = 8'd0; m_first = 1'b1; m_ovf = 1'b0;
    end else begin
      pp = (sb.size() > 0) && rdy;
      tk = e && (m_div == d);
      fl = (sb.size() == DEPTH);
      ps = tk && (!fl || pp);
      dr = tk && fl && !pp;
      if (pp) void'(sb.pop_front());
      if (ps) begin
        s.value = c;
        s.delta = m_first ? 8'h00 : 8'(c - m_prev);
        s.first = m_first;
        sb.push_back(s);
        m_prev  = c;
        m_first = 1'b0;
      end
      if (!e) m_first = 1'b1;
      m_div = !e ? 8'd0 : (tk ? 8'd0 : 8'(m_div + 8'd1));
      if (dr)       m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", level); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    n_vec++; if ({out_data, out_delta, out_first} !== 17'd0) begin n_err++;
      $display("FAIL reset_head got %h/%h/%b exp 0/0/0", out_data, out_delta, out_first); end
`ifdef COUNTER_SAMPLE_FIFO_DROP_CNT_EN
    n_vec++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_dropcnt got %0d exp 0", drop_cnt); end
`endif
  endtask

  task automatic test_basic();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 8'(8'h10 + i), 1, 0);
      n_vec++; if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + i)) begin n_err++;
        $display("FAIL basic_data[%0d] got v=%b %h exp v=1 %h", i, out_valid, out_data, 8'(8'h10 + i)); end
      n_vec++; if (out_delta !== ((i == 0) ? 8'h00 : 8'h01) || out_first !== (i == 0)) begin n_err++;
        $display("FAIL basic_delta[%0d] got d=%h f=%b exp d=%h f=%b", i, out_delta, out_first,
                 (i == 0) ? 8'h00 : 8'h01, i == 0); end
    end
  endtask

  task automatic test_divider();
    for (int j = 0; j < 16; j++) begin
      drive(0, 1, 3, 8'(8'h16 + j), 1, 0);
      if (j >= 1) begin
        n_vec++; if (out_valid !== (j % 4 == 3)) begin n_err++;
          $display("FAIL div_valid[%0d] got %b exp %b", j, out_valid, j % 4 == 3); end
        if (j % 4 == 3) begin
          n_vec++; if (out_data !== 8'(8'h16 + j) || out_delta !== 8'h04) begin n_err++;
            $display("FAIL div_sample[%0d] got %h/%h exp %h/04", j, out_data, out_delta, 8'(8'h16 + j)); end
        end
      end
    end
  endtask

  task automatic test_wrap();
    drive(0, 1, 0, 8'hFE, 1, 0);
    n_vec++; if (out_data !== 8'hFE || out_delta !== sb[0].delta) begin n_err++;
      $display("FAIL wrap_fe got %h/%h exp fe/%h", out_data, out_delta, sb[0].delta); end
    drive(0, 1, 0, 8'h03, 1, 0);
    n_vec++; if (out_data !== 8'h03 || out_delta !== 8'h05 || out_first !== 1'b0) begin n_err++;
      $display("FAIL wrap_delta got %h/%h/%b exp 03/05/0", out_data, out_delta, out_first); end
  endtask

  task automatic test_full();
    logic [7:0] ev [4];
    logic [7:0] ed [4];
    ev[0] = 8'h21; ev[1] = 8'h22; ev[2] = 8'h23; ev[3] = 8'h26;
    ed[0] = 8'h01; ed[1] = 8'h01; ed[2] = 8'h01; ed[3] = 8'h03;
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL full_drain got %0d exp 0", level); end
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 8'(8'h20 + i), 0, 0);
    n_vec++; if (level !== 3'd4 || overflow !== 1'b1) begin n_err++;
      $display("FAIL full_state got lvl=%0d ovf=%b exp lvl=4 ovf=1", level, overflow); end
    n_vec++; if (out_data !== 8'h20 || out_delta !== 8'h00 || out_first !== 1'b1) begin n_err++;
      $display("FAIL full_head got %h/%h/%b exp 20/00/1", out_data, out_delta, out_first); end
`ifdef COUNTER_SAMPLE_FIFO_DROP_CNT_EN
    n_vec++; if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL full_dropcnt got %0d exp 2", drop_cnt); end
`endif
    drive(0, 1, 0, 8'h26, 1, 0);
    n_vec++; if (level !== 3'd4 || level !== 3'(sb.size())) begin n_err++;
      $display("FAIL full_pushpop_level got %0d exp 4", level); end
    n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL full_pushpop_ovf got %b exp %b", overflow, m_ovf); end
`ifdef COUNTER_SAMPLE_FIFO_DROP_CNT_EN
    n_vec++; if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL full_pushpop_dropcnt got %0d exp 2", drop_cnt); end
`endif
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (out_valid !== 1'b1 || out_data !== ev[k] || out_delta !== ed[k] || out_first !== 1'b0) begin n_err++;
        $display("FAIL full_order[%0d] got v=%b %h/%h/%b exp 1 %h/%h/0", k, out_valid, out_data,
                 out_delta, out_first, ev[k], ed[k]); end
      drive(0, 0, 0, 0, 1, 0);
    end
    n_vec++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_err++;
      $display("FAIL full_empty got v=%b lvl=%0d exp 0/0", out_valid, level); end
  endtask

  task automatic test_ovf_clr();
    drive(0, 0, 0, 0, 1, 1);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clr_ovf got %b exp 0", overflow); end
`ifdef COUNTER_SAMPLE_FIFO_DROP_CNT_EN
    n_vec++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL clr_dropcnt got %0d exp 0", drop_cnt); end
`endif
    drive(0, 1, 0, 8'h50, 1, 0);
    drive(0, 0, 0, 8'h51, 1, 0);
    drive(0, 1, 0, 8'h60, 1, 0);
    n_vec++; if (out_data !== 8'h60 || out_delta !== 8'h00 || out_first !== 1'b1) begin n_err++;
      $display("FAIL en_toggle_first got %h/%h/%b exp 60/00/1", out_data, out_delta, out_first); end
    drive(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_set_wins();
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 8'(8'h40 + i), 0, 0);
    n_vec++; if (level !== 3'd4 || overflow !== 1'b0) begin n_err++;
      $display("FAIL setwins_pre got lvl=%0d ovf=%b exp 4/0", level, overflow); end
    drive(0, 1, 0, 8'h44, 0, 1);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL setwins_ovf got %b exp 1", overflow); end
`ifdef COUNTER_SAMPLE_FIFO_DROP_CNT_EN
    n_vec++; if (drop_cnt !== 16'd1) begin n_err++; $display("FAIL setwins_dropcnt got %0d exp 1", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 8'(8'h70 + i), 0, 0);
    n_vec++; if (level !== 3'd3 || overflow !== 1'b1) begin n_err++;
      $display("FAIL rstmid_pre got lvl=%0d ovf=%b exp 3/1", level, overflow); end
    drive(1, 1, 0, 8'h73, 0, 0);
    n_vec++; if (level !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin n_err++;
      $display("FAIL rstmid_state got lvl=%0d v=%b ovf=%b exp 0/0/0", level, out_valid, overflow); end
    drive(0, 1, 0, 8'h80, 1, 0);
    n_vec++; if (out_data !== 8'h80 || out_delta !== 8'h00 || out_first !== 1'b1) begin n_err++;
      $display("FAIL rstmid_first got %h/%h/%b exp 80/00/1", out_data, out_delta, out_first); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; div = 8'd0; cnt_in = 8'd0; out_ready = 1'b0; ovf_clr = 1'b0;
    m_div = 8'd0; m_prev = 8'd0; m_first = 1'b1; m_ovf = 1'b0;
    test_reset();
    test_basic();
    test_divider();
    test_wrap();
    test_full();
    test_ovf_clr();
    test_set_wins();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
